// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the counter-width helper.
package serial_subtractor_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold the value WIDTH without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle of the serial subtractor; master drives operands,
// slave (the controller) returns status and result.
interface serial_subtractor_ctrl_if
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor assembled from two half subtractors; the borrow out
// is the OR of the two stage borrows.
module full_subtractor (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  half_subtractor u_hs0 (.x(ai), .y(bi),  .d(d1), .b(b1));
  half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .b(b2));

  assign bout = b1 | b2;
endmodule

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);
  assign d = x ^ y;
  assign b = ~x & y;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b controller: captures operands, processes one bit per clock
// LSB first, and publishes diff/bout only when the last bit is done.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_subtractor_ctrl_if.slave  bus
);
  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_bit, br_nxt, last_bit;

  full_subtractor u_fs (
    .ai  (a_sh_q[0]),
    .bi  (b_sh_q[0]),
    .bin (br_q),
    .d   (d_bit),
    .bout(br_nxt)
  );

  assign last_bit = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.diff = diff_q;
    bus.bout = bout_q;
  end

  // Datapath: result bits enter at the MSB so the LSB lands in bit 0 at the end.
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    res_d  = res_q;
    diff_d = diff_q;
    br_d   = br_q;
    bout_d = bout_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d = bus.a;
          b_sh_d = bus.b;
          res_d  = '0;
          br_d   = 1'b0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        a_sh_d           = a_sh_q >> 1;
        b_sh_d           = b_sh_q >> 1;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = d_bit;
        br_d             = br_nxt;
        cnt_d            = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d = res_d;
          bout_d = br_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      res_q  <= res_d;
      diff_q <= diff_d;
      br_q   <= br_d;
      bout_q <= bout_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: 8-bit and 1-bit instances, results checked
// against an arithmetic model through per-instance scoreboards.
module tb_serial_subtractor_ctrl;
  import serial_subtractor_ctrl_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   done8;
  int   done1;
  exp_t sb8[$];
  exp_t sb1[$];

  serial_subtractor_ctrl_if #(.WIDTH(W)) bus8 ();
  serial_subtractor_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_subtractor_ctrl #(.WIDTH(W)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] r;
    exp_t e;
    r      = {1'b0, av} - {1'b0, bv};
    e.diff = 32'(r[7:0]);
    e.bout = r[8];
    return e;
  endfunction

  function automatic exp_t model1(input logic av, input logic bv);
    logic [1:0] r;
    exp_t e;
    r      = {1'b0, av} - {1'b0, bv};
    e.diff = 32'(r[0]);
    e.bout = r[1];
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus8.done) begin
      exp_t e;
      done8++;
      chk("sb8_nonempty", 32'(sb8.size() > 0), 32'd1);
      if (sb8.size() > 0) begin
        e = sb8.pop_front();
        chk("diff8", 32'(bus8.diff), e.diff);
        chk("bout8", 32'(bus8.bout), 32'(e.bout));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus1.done) begin
      exp_t e;
      done1++;
      chk("sb1_nonempty", 32'(sb1.size() > 0), 32'd1);
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        chk("diff1", 32'(bus1.diff), e.diff);
        chk("bout1", 32'(bus1.bout), 32'(e.bout));
      end
    end
  end

  task automatic op8(input logic [7:0] av, input logic [7:0] bv);
    int n;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    sb8.push_back(model8(av, bv));
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    chk("busy_accept8", 32'(bus8.busy), 32'd1);
    n = 1;
    while (!bus8.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency8", 32'(n), 32'(W + 1));
    @(posedge clk); #1;
  endtask

  task automatic op1(input logic av, input logic bv);
    int n;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.a     = av;
    bus1.b     = bv;
    sb1.push_back(model1(av, bv));
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus1.a     = ~av;
    bus1.b     = ~bv;
    chk("busy_accept1", 32'(bus1.busy), 32'd1);
    n = 1;
    while (!bus1.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency1", 32'(n), 32'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int dc;
    bit seen_idle;
    n_chk      = 0;
    n_fail     = 0;
    done8      = 0;
    done1      = 0;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    #23;
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_diff", 32'(bus8.diff), 32'd0);
    chk("rst_bout", 32'(bus8.bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'h5A, 8'h3C);
    op8(8'h00, 8'h01);
    op8(8'hA5, 8'hA5);
    op8(8'h01, 8'hFF);

    // start held high with operands changing every cycle during RUN
    @(negedge clk);
    dc         = done8;
    bus8.start = 1'b1;
    bus8.a     = 8'h33;
    bus8.b     = 8'h44;
    sb8.push_back(model8(8'h33, 8'h44));
    n = 0;
    while (!bus8.done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!bus8.done) begin
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
      end
    end
    bus8.start = 1'b0;
    chk("held_latency", 32'(n), 32'(W + 1));
    repeat (4) @(posedge clk);
    #1;
    chk("held_busy", 32'(bus8.busy), 32'd0);
    chk("held_once", 32'(done8 - dc), 32'd1);

    // reset during RUN aborts without done
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'hC3;
    bus8.b     = 8'h3C;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_diff", 32'(bus8.diff), 32'd0);
    chk("abort_bout", 32'(bus8.bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc    = done8;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(done8 - dc), 32'd0);
    chk("abort_idle", 32'(bus8.busy), 32'd0);
    op8(8'h80, 8'h7F);

    // back-to-back issue with start held across DONE
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'hFF;
    bus8.b     = 8'h80;
    sb8.push_back(model8(8'hFF, 8'h80));
    sb8.push_back(model8(8'h10, 8'h20));
    @(posedge clk); #1;
    bus8.a    = 8'h10;
    bus8.b    = 8'h20;
    n         = 0;
    seen_idle = 1'b0;
    while (n < 40 && !(seen_idle && bus8.busy)) begin
      @(posedge clk); #1;
      n++;
      if (!bus8.busy) seen_idle = 1'b1;
    end
    bus8.start = 1'b0;
    chk("b2b_interval", 32'(n), 32'(W + 2));
    n = 0;
    while (!bus8.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_second_done", 32'(bus8.done), 32'd1);
    @(posedge clk); #1;

    op1(1'b0, 1'b0);
    op1(1'b0, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    chk("done1_count", 32'(done1), 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
